// File: rtl/board_io_ctrl_if.sv
// Single-cycle register port between the SoC bus and board_io_ctrl.
// The master issues req/we/addr/wdata; the slave returns ack/rdata one cycle later.
interface board_io_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;

    modport master (output req_i, we_i, addr_i, wdata_i, input  ack_o, rdata_o);
    modport slave  (input  req_i, we_i, addr_i, wdata_i, output ack_o, rdata_o);
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O controller: synchronised/debounced buttons and switches, button-press interrupts,
// LED register. Optional LED brightness PWM when BOARD_IO_LED_PWM_EN is defined.
module board_io_deb #(
    parameter int DEB_CYCLES  = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_s == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= w_s;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_stable = r_stable;
    // Pulses on the same edge that stable goes 0->1.
    assign o_rise   = w_s & ~r_stable & (r_cnt == CNT_MAX);
endmodule

module board_io_ctrl #(
    parameter int N_BTN       = 5,
    parameter int N_SW        = 16,
    parameter int N_LED       = 16,
    parameter int DEB_CYCLES  = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_BTN-1:0]   btn_i,
    input  logic [N_SW-1:0]    sw_i,
    output logic [N_LED-1:0]   led_o,
    output logic               irq_o,
    board_io_ctrl_if.slave     bus
);
    logic [N_BTN-1:0] w_btn_stable, w_btn_rise, w_w1c;
    logic [N_SW-1:0]  w_sw_stable, w_sw_rise_unused;
    logic [N_LED-1:0] r_led;
    logic [N_BTN-1:0] r_mask, r_pend;
    logic             r_ack, r_irq;
    logic [31:0]      r_rdata, w_rd;
    logic             w_wr, w_rd_en, w_unused;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        board_io_deb #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb (
            .clk_i(clk_i), .rst_i(rst_i), .i_raw(btn_i[g]),
            .o_stable(w_btn_stable[g]), .o_rise(w_btn_rise[g]));
    end
    for (genvar g = 0; g < N_SW; g++) begin : g_sw
        board_io_deb #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb (
            .clk_i(clk_i), .rst_i(rst_i), .i_raw(sw_i[g]),
            .o_stable(w_sw_stable[g]), .o_rise(w_sw_rise_unused[g]));
    end

    assign w_wr    = bus.req_i & bus.we_i;
    assign w_rd_en = bus.req_i & ~bus.we_i;
    assign w_w1c   = (w_wr && bus.addr_i == 3'd4) ? bus.wdata_i[N_BTN-1:0] : '0;

`ifdef BOARD_IO_LED_PWM_EN
    logic [7:0]       r_bright, r_pwm;
    logic [N_LED-1:0] r_led_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bright <= 8'hFF;
            r_pwm    <= 8'h00;
            r_led_q  <= '0;
        end else begin
            if (w_wr && bus.addr_i == 3'd5) r_bright <= bus.wdata_i[7:0];
            r_pwm   <= r_pwm + 8'd1;
            r_led_q <= r_led & {N_LED{r_pwm < r_bright}};
        end
    end
    assign led_o = r_led_q;
`else
    assign led_o = r_led;
`endif

    always_comb begin
        w_rd = '0;
        case (bus.addr_i)
            3'd0: w_rd[N_SW-1:0]  = w_sw_stable;
            3'd1: w_rd[N_BTN-1:0] = w_btn_stable;
            3'd2: w_rd[N_LED-1:0] = r_led;
            3'd3: w_rd[N_BTN-1:0] = r_mask;
            3'd4: w_rd[N_BTN-1:0] = r_pend;
`ifdef BOARD_IO_LED_PWM_EN
            3'd5: w_rd[7:0]       = r_bright;
`endif
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_led   <= '0;
            r_mask  <= '0;
            r_pend  <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && bus.addr_i == 3'd2) r_led  <= bus.wdata_i[N_LED-1:0];
            if (w_wr && bus.addr_i == 3'd3) r_mask <= bus.wdata_i[N_BTN-1:0];
            // A press landing with a W1C of the same bit keeps the bit set.
            r_pend  <= (r_pend & ~w_w1c) | w_btn_rise;
            r_ack   <= bus.req_i;
            r_rdata <= w_rd_en ? w_rd : 32'd0;
            r_irq   <= |(r_pend & r_mask);
        end
    end

    assign bus.ack_o   = r_ack;
    assign bus.rdata_o = r_rdata;
    assign irq_o       = r_irq;
    assign w_unused    = ^{bus.wdata_i, w_sw_rise_unused};
endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed self-checking bench for board_io_ctrl with DEB_CYCLES=4, SYNC_STAGES=2.
module tb_board_io_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn = '0;
    logic [15:0] sw  = '0;
    logic [15:0] led;
    logic        irq;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    int          cnt;
    logic        irq_seen;

    board_io_ctrl_if bus();

    board_io_ctrl #(.N_BTN(5), .N_SW(16), .N_LED(16), .DEB_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .btn_i(btn), .sw_i(sw), .led_o(led), .irq_o(irq), .bus(bus));

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic w, input logic [2:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a; bus.wdata_i = d;
        step();
        check("ack", {31'd0, bus.ack_o}, 32'd1);
        r = bus.rdata_o;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.wdata_i = '0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        acc(1'b1, a, d, r);
        check("wr_rdata_zero", r, 32'd0);
    endtask

    task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        acc(1'b0, a, 32'd0, r);
        check(tag, r, exp);
    endtask

    initial begin
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        step(2);
        check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_ack", {31'd0, bus.ack_o}, 32'd0);

        // Switches and register map
        sw = 16'h1234;
        step(8);
        rchk("sw_read", 3'd0, 32'h0000_1234);
        wr(3'd2, 32'h0000_A5A5);
`ifndef BOARD_IO_LED_PWM_EN
        check("led_out", {16'd0, led}, 32'h0000_A5A5);
        step();
        check("led_out_hold", {16'd0, led}, 32'h0000_A5A5);
`endif
        rchk("led_read", 3'd2, 32'h0000_A5A5);
        wr(3'd2, 32'hFFFF_FFFF);
        rchk("led_upper_ignored", 3'd2, 32'h0000_FFFF);
        rchk("reg6_zero", 3'd6, 32'd0);
        wr(3'd7, 32'hFFFF_FFFF);
        rchk("reg7_zero", 3'd7, 32'd0);
`ifdef BOARD_IO_LED_PWM_EN
        rchk("bright_rst", 3'd5, 32'h0000_00FF);
`else
        wr(3'd5, 32'h0000_0012);
        rchk("reg5_zero", 3'd5, 32'd0);
`endif

        // Short bounces on btn[1] never qualify
        wr(3'd3, 32'h0000_0003);
        irq_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn[1] = 1'b1;
            for (int c = 0; c < 3; c++) begin step(); irq_seen |= irq; end
            btn[1] = 1'b0;
            for (int c = 0; c < 3; c++) begin step(); irq_seen |= irq; end
        end
        step(4);
        irq_seen |= irq;
        check("bounce_irq", {31'd0, irq_seen}, 32'd0);
        rchk("bounce_btn", 3'd1, 32'd0);
        rchk("bounce_pend", 3'd4, 32'd0);

        // Clean press on btn[0]: stable after exactly 6 edges, irq one edge later
        wr(3'd3, 32'h0000_0001);
        btn[0] = 1'b1;
        step(5);
        check("press_irq_e5", {31'd0, irq}, 32'd0);
        rchk("press_btn_e6", 3'd1, 32'd0);
        check("press_irq_e6", {31'd0, irq}, 32'd0);
        step();
        check("press_irq_e7", {31'd0, irq}, 32'd1);
        rchk("press_btn", 3'd1, 32'h0000_0001);
        rchk("press_pend", 3'd4, 32'h0000_0001);

        // W1C colliding with a new press edge: set wins
        btn[0] = 1'b0;
        step(8);
        rchk("release_btn", 3'd1, 32'd0);
        btn[0] = 1'b1;
        step(5);
        wr(3'd4, 32'h0000_0001);
        rchk("collide_pend", 3'd4, 32'h0000_0001);
        wr(3'd4, 32'h0000_0001);
        check("clear_irq_same", {31'd0, irq}, 32'd1);
        step();
        check("clear_irq_next", {31'd0, irq}, 32'd0);
        rchk("clear_pend", 3'd4, 32'd0);

        // Reset mid-debounce and during a read
        wr(3'd3, 32'h0000_0005);
        btn[2] = 1'b1;
        step(8);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        btn[3] = 1'b1;
        step(3);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 3'd2;
        rst = 1'b1;
        step();
        check("mid_rst_ack", {31'd0, bus.ack_o}, 32'd0);
        check("mid_rst_rdata", bus.rdata_o, 32'd0);
        check("mid_rst_led", {16'd0, led}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0; bus.req_i = 1'b0;
        step(5);
        rchk("post_rst_btn_e6", 3'd1, 32'd0);
        rchk("post_rst_btn_e7", 3'd1, 32'h0000_000D);
        rchk("post_rst_pend", 3'd4, 32'h0000_000D);
        rchk("post_rst_mask", 3'd3, 32'd0);
        rchk("post_rst_led", 3'd2, 32'd0);
        check("post_rst_irq", {31'd0, irq}, 32'd0);

`ifdef BOARD_IO_LED_PWM_EN
        wr(3'd2, 32'h0000_FFFF);
        wr(3'd5, 32'h0000_0040);
        rchk("bright_read", 3'd5, 32'h0000_0040);
        step(2);
        cnt = 0;
        for (int c = 0; c < 256; c++) begin
            if (led == 16'hFFFF) cnt++;
            step();
        end
        check("pwm_duty_64", cnt, 32'd64);
        wr(3'd5, 32'h0000_0000);
        step(2);
        cnt = 0;
        for (int c = 0; c < 256; c++) begin
            if (led != 16'h0000) cnt++;
            step();
        end
        check("pwm_off", cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised board I/O controller that replaces the fixed switch/LED/button wiring of a board top level with one reusable block. It synchronises and debounces N buttons and N switches, and latches button presses as maskable interrupts. It drives LEDs from a software register. A small single-cycle register port connects it to the SoC-side bus.

Parameters:
N_BTN, 5, number of push-button inputs (1..32)
N_SW, 16, number of slide-switch inputs (1..32)
N_LED, 16, number of LED outputs (1..32)
DEB_CYCLES, 100000, stable cycles required before a debounced input changes (>=2)
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, synchronous, active-high
btn_i  input  N_BTN  raw asynchronous buttons, 1 = pressed
sw_i  input  N_SW  raw asynchronous switches
led_o  output  N_LED  LED drive, 1 = on
req_i  input  1  register access request
we_i  input  1  1 = write, 0 = read
addr_i  input  3  word register index
wdata_i  input  32  write data
ack_o  output  1  access done, one-cycle pulse
rdata_o  output  32  read data, valid while ack_o = 1
irq_o  output  1  level interrupt = |(pend & mask), registered

Behaviour:
- Reset: every synchroniser stage, stable value, debounce counter, led register, mask, pend, ack_o, rdata_o and irq_o are cleared to 0. This holds regardless of any access in flight.
- Sync: each input passes through SYNC_STAGES flops. The synchronised value is s.
- Debounce (per input): while s == stable, cnt = 0. While s != stable, cnt increments. When cnt == DEB_CYCLES-1 and s still differs, stable <= s and cnt <= 0.
  - Any bounce back clears cnt.
  - Counter width is $clog2(DEB_CYCLES).
  - Raw-to-stable latency is SYNC_STAGES + DEB_CYCLES cycles.
- Edge: a button stable 0->1 transition sets pend[i] on the same edge that stable updates.
- Registers (unused upper bits read 0, writes to them are ignored):
  - 0 SW: stable switches, read-only.
  - 1 BTN: stable buttons, read-only.
  - 2 LED: read/write, N_LED bits.
  - 3 MASK: read/write, N_BTN bits.
  - 4 PEND: read; writing 1 clears that bit (W1C).
  - 5: see the optional feature.
  - 6-7: read 0, writes ignored.
- Handshake: a request sampled high produces ack_o = 1 exactly one cycle later, with rdata_o valid in that cycle.
  - rdata_o is 0 for writes and when idle.
  - Back-to-back requests give back-to-back acks.
  - Writes take effect on the sampling edge.
- Simultaneous W1C of bit i and a new press on i: set wins, so pend[i] stays 1.
- irq_o is registered: it reflects pend and mask one cycle after either changes.
- led_o = LED register when the optional feature is off; it follows the register one cycle after the write.

Optional Feature:
Macro BOARD_IO_LED_PWM_EN.
- Defined:
  - Register 5 is BRIGHT, an 8-bit read/write field; its reset value is 8'hFF.
  - A free-running 8-bit counter pwm runs, cleared by reset.
  - led_o = LED & {N_LED{pwm < BRIGHT}}, registered.
  - BRIGHT = 0 forces all LEDs off.
  - BRIGHT = 255 gives 255/256 duty.
- Undefined:
  - Register 5 reads 0 and writes to it are ignored.
  - No PWM logic is present.
  - led_o is the LED register directly.

Test Plan:
1. DEB_CYCLES=4, SYNC_STAGES=2: btn_i[0] rises and holds → BTN[0] = 1 exactly 6 cycles later; PEND = 0x1; with MASK = 0x1, irq_o = 1 one cycle after pend sets.
2. btn_i[1] pulses high for 3 cycles, then drops, repeated 5 times → BTN stays 0, PEND stays 0, irq_o stays 0.
3. Write LED = 0xA5A5 → ack_o one cycle later with rdata_o = 0; led_o = 0xA5A5 on the next cycle; read LED returns 0x0000A5A5.
4. PEND[0] = 1, then W1C 0x1 in the same cycle that a new btn_i[0] debounced edge lands → PEND[0] remains 1; a later W1C clears it and irq_o drops one cycle after the clear.
5. rst_i asserted mid-debounce and during a pending read → next cycle ack_o = 0, led_o = 0, irq_o = 0, PEND = 0; after release, a held input needs the full SYNC_STAGES + DEB_CYCLES again.
6. BOARD_IO_LED_PWM_EN defined, LED = 0xFFFF, BRIGHT = 64 → led_o is high for 64 of every 256 cycles; BRIGHT = 0 → led_o is constant 0.
